// File: rtl/dcache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dcache_pkg : shared state encoding and geometry helpers for dcache |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_e;

  function automatic int calc_tag_w(input int addr_w, input int index_w);
    return addr_w - index_w - 2;
  endfunction

  function automatic int line_count(input int index_w);
    return 1 << index_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_wt_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dcache_wt_if : pipeline-side and backing-memory-side cache signals |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
interface dcache_wt_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_read_i;
  logic              cpu_write_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  // The cache itself: serves the pipeline, drives the memory bus.
  modport slave (
    input  cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  // The surroundings: pipeline plus backing memory.
  modport master (
    output cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dcache_array : valid/tag/data storage, async read, sync write      |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 26,
  parameter int DATA_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [DATA_W-1:0]  rd_data_o,
  input  logic               wr_en_i,
  input  logic               wr_fill_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [DATA_W-1:0]  wr_data_i
);
  localparam int LINES = line_count(INDEX_W);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en_i && wr_fill_i) begin
      valid_d[wr_index_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data are left untouched by reset; only the valid bits matter.
  always_ff @(posedge clk_i) begin
    if (rst_i && wr_en_i) begin
      data_q[wr_index_i] <= wr_data_i;
      if (wr_fill_i) begin
        tag_q[wr_index_i] <= wr_tag_i;
      end
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule
`default_nettype wire

// File: rtl/dcache_wt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dcache_wt : direct-mapped write-through no-allocate data cache     |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  dcache_wt_if.slave bus
);
  localparam int TAG_W   = calc_tag_w(ADDR_W, INDEX_W);
  localparam int WADDR_W = ADDR_W - 2;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [WADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [INDEX_W-1:0]  cur_index;
  logic [TAG_W-1:0]    cur_tag;
  logic                arr_valid;
  logic [TAG_W-1:0]    arr_tag;
  logic [DATA_W-1:0]   arr_data;
  logic                arr_wr_en, arr_wr_fill;
  logic [INDEX_W-1:0]  arr_wr_index;
  logic [TAG_W-1:0]    arr_wr_tag;
  logic [DATA_W-1:0]   arr_wr_data;
  logic                hit, stall;
  logic [DATA_W-1:0]   cpu_rdata;
  logic                unused_addr_bits;

  assign cur_index        = bus.cpu_addr_i[INDEX_W+1:2];
  assign cur_tag          = bus.cpu_addr_i[ADDR_W-1:INDEX_W+2];
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];
  assign hit              = arr_valid && (arr_tag == cur_tag);

  dcache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_array (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_index_i (cur_index),
    .rd_valid_o (arr_valid),
    .rd_tag_o   (arr_tag),
    .rd_data_o  (arr_data),
    .wr_en_i    (arr_wr_en),
    .wr_fill_i  (arr_wr_fill),
    .wr_index_i (arr_wr_index),
    .wr_tag_i   (arr_wr_tag),
    .wr_data_i  (arr_wr_data)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    stall        = 1'b0;
    cpu_rdata    = rdata_q;
    arr_wr_en    = 1'b0;
    arr_wr_fill  = 1'b0;
    arr_wr_index = cur_index;
    arr_wr_tag   = cur_tag;
    arr_wr_data  = bus.cpu_wdata_i;

    case (state_q)
      IDLE: begin
        // A store wins over a load presented in the same cycle.
        if (bus.cpu_write_i) begin
          stall     = 1'b1;
          arr_wr_en = hit;
          waddr_d   = bus.cpu_addr_i[ADDR_W-1:2];
          wdata_d   = bus.cpu_wdata_i;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
          state_d   = WR_WAIT;
        end else if (bus.cpu_read_i) begin
          if (hit) begin
            cpu_rdata = arr_data;
            rdata_d   = arr_data;
          end else begin
            stall     = 1'b1;
            waddr_d   = bus.cpu_addr_i[ADDR_W-1:2];
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (bus.mem_ack_i) begin
          arr_wr_en    = 1'b1;
          arr_wr_fill  = 1'b1;
          arr_wr_index = waddr_q[INDEX_W-1:0];
          arr_wr_tag   = waddr_q[WADDR_W-1:INDEX_W];
          arr_wr_data  = bus.mem_rdata_i;
          rdata_d      = bus.mem_rdata_i;
          mem_req_d    = 1'b0;
          state_d      = RESP;
        end
      end
      WR_WAIT: begin
        stall = 1'b1;
        if (bus.mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.cpu_rdata_o = cpu_rdata;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = {waddr_q, 2'b00};
  assign bus.mem_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the EX/MEM pipeline register and a multi-cycle backing data memory.
- Pipeline side: read hits complete with zero stall; misses and all writes raise stall_o until the backing memory acks.
- Memory side: single outstanding req/ack transaction.
- Replaces the ideal single-cycle data memory in the MEM stage.

Parameters:
- INDEX_W, 4, index bits; line count = 2**INDEX_W, one 32-bit word per line
- ADDR_W, 32, address width; tag width TAG_W = ADDR_W - INDEX_W - 2
- DATA_W, 32, data word width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-low
- cpu_read_i  in  1  MEM-stage load request, held stable while stall_o=1
- cpu_write_i  in  1  MEM-stage store request, held stable while stall_o=1
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata_i  in  DATA_W  store data
- cpu_rdata_o  out  DATA_W  load data
- stall_o  out  1  freeze PC/IF_ID/ID_EX/EX_MEM this cycle
- mem_req_o  out  1  backing-memory request, registered
- mem_we_o  out  1  1 = write, 0 = read, registered
- mem_addr_o  out  ADDR_W  word-aligned request address, registered
- mem_wdata_o  out  DATA_W  write data, registered
- mem_rdata_i  in  DATA_W  read data, valid when mem_ack_i=1
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address split: index = addr[INDEX_W+1:2], tag = addr[ADDR_W-1:INDEX_W+2]. hit = valid[index] && tag match.
- States: IDLE, RD_WAIT, WR_WAIT, RESP.
- Reset (rst_i=0 at an edge):
  - state goes to IDLE; all valid bits cleared.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, cpu_rdata_o all 0.
  - Data and tag arrays are not cleared.
  - Reset mid-transaction abandons it: mem_req_o is 0 from the next cycle and any later mem_ack_i is ignored.
- Request priority: cpu_write_i beats cpu_read_i when both are high; the access is treated as a write.
- IDLE, read hit:
  - cpu_rdata_o = array data, combinational, same cycle; stall_o=0.
  - No state change; no memory traffic.
- IDLE, read miss:
  - stall_o=1 combinationally.
  - Latch address; go to RD_WAIT with mem_req_o=1, mem_we_o=0.
- IDLE, write:
  - stall_o=1.
  - On hit, update the data word at this edge (tag/valid unchanged). On miss, leave the cache untouched (no allocate).
  - Latch address and data; go to WR_WAIT with mem_req_o=1, mem_we_o=1.
- RD_WAIT / WR_WAIT:
  - stall_o=1; mem_req_o and the mem_* fields held stable until the mem_ack_i cycle.
  - On ack in RD_WAIT: write mem_rdata_i, tag and valid=1 into the line (evicting any conflicting line), latch data into the response register, go to RESP, mem_req_o=0.
  - On ack in WR_WAIT: go to RESP, mem_req_o=0.
- RESP:
  - stall_o=0; cpu_rdata_o = latched response data (reads).
  - Lets the pipeline advance exactly once without re-issuing; next state IDLE.
- mem_ack_i is ignored in IDLE and RESP.
- Read-miss stall length = 1 + k cycles, where k = RD_WAIT cycles including the ack cycle; write stall is the same.
- With no request in IDLE: stall_o=0 and cpu_rdata_o holds its last value.

Decomposition:
- Shared package dcache_pkg:
  - state enum (IDLE, RD_WAIT, WR_WAIT, RESP)
  - TAG_W / index-slice helper functions
- One sub-module, dcache_array:
  - valid/tag/data storage
  - one combinational read port
  - one synchronous write port
  - synchronous valid-clear on reset
- FSM, request registers and stall logic stay in dcache_wt.

Test Plan:
- Read-miss fill: after reset, read 0x0000_0040; ack after 3 request cycles with 0xDEADBEEF → stall_o=1 for 4 cycles; RESP cpu_rdata_o=0xDEADBEEF with stall_o=0; re-read 0x40 → hit, zero stall, mem_req_o stays 0.
- Conflict eviction: fill 0x40, then read 0x80 (same index 0, different tag) → miss, fill; re-read 0x40 → miss again.
- Write hit: with 0x40 cached, write 0x12345678 → mem_req_o=1, mem_we_o=1, mem_addr_o=0x40, mem_wdata_o=0x12345678 until ack; later read 0x40 → hit returning 0x12345678.
- Write miss: write 0x100 = 0xA5A5A5A5 → memory write issued; then read 0x100 → miss with a memory read.
- Reset mid-RD_WAIT: reset during an outstanding read → mem_req_o=0 and stall_o=0 the next cycle; a late ack is ignored; previously cached 0x40 now misses.
- Simultaneous request: cpu_read_i=cpu_write_i=1 on 0x40 → write transaction (mem_we_o=1); no read fill occurs.
